// File: rtl/div_unit_controller_if.sv
// Handshake/status bundle between issue/execute/access stages, divider datapath and the lane controller.
// master = pipeline/datapath side, slave = div_unit_controller.
interface div_unit_controller_if #(
    parameter int ISSUE_WIDTH    = 1,
    parameter int AL_INDEX_WIDTH = 6
);
    logic                                         stall;
    logic [ISSUE_WIDTH-1:0]                       acquire;
    logic [ISSUE_WIDTH-1:0][AL_INDEX_WIDTH-1:0]   acquire_ptr;
    logic [ISSUE_WIDTH-1:0]                       req;
    logic [ISSUE_WIDTH-1:0]                       divisor_is_zero;
    logic [ISSUE_WIDTH-1:0]                       rel;
    logic                                         flush_valid;
    logic                                         flush_all;
    logic [AL_INDEX_WIDTH-1:0]                    flush_head_ptr;
    logic [AL_INDEX_WIDTH-1:0]                    flush_ptr;
    logic [ISSUE_WIDTH-1:0]                       div_start;
    logic [ISSUE_WIDTH-1:0]                       div_abort;
    logic [ISSUE_WIDTH-1:0]                       div_free;
    logic [ISSUE_WIDTH-1:0]                       div_reserved;
    logic [ISSUE_WIDTH-1:0]                       div_busy;
    logic [ISSUE_WIDTH-1:0]                       div_finished;
    logic                                         any_free;

    modport master (
        output stall, acquire, acquire_ptr, req, divisor_is_zero, rel,
               flush_valid, flush_all, flush_head_ptr, flush_ptr,
        input  div_start, div_abort, div_free, div_reserved, div_busy, div_finished, any_free
    );

    modport slave (
        input  stall, acquire, acquire_ptr, req, divisor_is_zero, rel,
               flush_valid, flush_all, flush_head_ptr, flush_ptr,
        output div_start, div_abort, div_free, div_reserved, div_busy, div_finished, any_free
    );
endinterface

// File: rtl/div_unit_controller.sv
// Per-lane divider lifecycle FSM (FREE/RESERVED/BUSY/FINISHED) with age-based flush; RSD_DIV_EARLY_FINISH_EN finishes div-by-zero in one cycle.
// Latency: status registered (state flops are one-hot), divStart/divAbort combinational; accepted req finishes after DIV_LATENCY cycles.
// Backpressure: stall only blocks req acceptance; a running division keeps counting, lower-priority inputs are dropped not queued.
module div_unit_controller #(
    parameter int ISSUE_WIDTH    = 1,
    parameter int AL_INDEX_WIDTH = 6,
    parameter int DIV_LATENCY    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    div_unit_controller_if.slave  div_if
);
    localparam int CNT_W = $clog2(DIV_LATENCY);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // One-hot encoding so the status outputs are flop bits directly.
    typedef enum logic [3:0] {
        S_FREE = 4'b0001,
        S_RES  = 4'b0010,
        S_BUSY = 4'b0100,
        S_FIN  = 4'b1000
    } state_e;

    state_e                    state_q [ISSUE_WIDTH];
    state_e                    state_d [ISSUE_WIDTH];
    logic [CNT_W-1:0]          cnt_q   [ISSUE_WIDTH];
    logic [CNT_W-1:0]          cnt_d   [ISSUE_WIDTH];
    logic [AL_INDEX_WIDTH-1:0] owner_q [ISSUE_WIDTH];
    logic [AL_INDEX_WIDTH-1:0] owner_d [ISSUE_WIDTH];
    logic [AL_INDEX_WIDTH-1:0] owner_age [ISSUE_WIDTH];
    logic [AL_INDEX_WIDTH-1:0] flush_age;
    logic [ISSUE_WIDTH-1:0]    flush_hit;
    logic [ISSUE_WIDTH-1:0]    req_ok;

    // Ages are measured from the active-list head so pointer wrap-around compares correctly.
    assign flush_age = div_if.flush_ptr - div_if.flush_head_ptr;

    always_comb begin
        flush_hit = '0;
        req_ok    = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            owner_age[i] = owner_q[i] - div_if.flush_head_ptr;
            flush_hit[i] = div_if.flush_valid && (state_q[i] != S_FREE) &&
                           (div_if.flush_all || (owner_age[i] >= flush_age));
            req_ok[i]    = div_if.req[i] && !div_if.stall && (state_q[i] == S_RES) &&
                           !flush_hit[i] && !div_if.rel[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                state_q[i] <= S_FREE;
                cnt_q[i]   <= '0;
                owner_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                owner_q[i] <= owner_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            owner_d[i] = owner_q[i];
            if (flush_hit[i]) begin
                state_d[i] = S_FREE;
            end else begin
                case (state_q[i])
                    S_FREE: begin
                        if (div_if.acquire[i]) begin
                            state_d[i] = S_RES;
                            owner_d[i] = div_if.acquire_ptr[i];
                        end
                    end
                    S_RES: begin
                        if (div_if.rel[i]) begin
                            state_d[i] = S_FREE;
                        end else if (req_ok[i]) begin
`ifdef RSD_DIV_EARLY_FINISH_EN
                            state_d[i] = div_if.divisor_is_zero[i] ? S_FIN : S_BUSY;
                            cnt_d[i]   = div_if.divisor_is_zero[i] ? '0 : CNT_INIT;
`else
                            state_d[i] = S_BUSY;
                            cnt_d[i]   = CNT_INIT;
`endif
                        end
                    end
                    S_BUSY: begin
                        if (div_if.rel[i]) begin
                            state_d[i] = S_FREE;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                            if (cnt_q[i] == CNT_ONE) state_d[i] = S_FIN;
                        end
                    end
                    S_FIN: begin
                        if (div_if.rel[i]) state_d[i] = S_FREE;
                    end
                    default: state_d[i] = S_FREE;
                endcase
            end
        end
    end

`ifndef RSD_DIV_EARLY_FINISH_EN
    logic unused_divisor_is_zero;
    assign unused_divisor_is_zero = ^div_if.divisor_is_zero;
`endif

    always_comb begin
        div_if.div_start    = '0;
        div_if.div_abort    = '0;
        div_if.div_free     = '0;
        div_if.div_reserved = '0;
        div_if.div_busy     = '0;
        div_if.div_finished = '0;
        div_if.any_free     = 1'b0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            div_if.div_start[i]    = req_ok[i];
            div_if.div_abort[i]    = (state_q[i] == S_BUSY) && (flush_hit[i] || div_if.rel[i]);
            div_if.div_free[i]     = state_q[i][0];
            div_if.div_reserved[i] = state_q[i][1];
            div_if.div_busy[i]     = state_q[i][2];
            div_if.div_finished[i] = state_q[i][3];
            div_if.any_free        = div_if.any_free | state_q[i][0];
        end
    end
endmodule

// File: tb/tb_div_unit_controller.sv
// Directed bench for div_unit_controller: two lanes, DIV_LATENCY=32, hand-computed expectations.
module tb_div_unit_controller;
    localparam int IW  = 2;
    localparam int AW  = 6;
    localparam int LAT = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_controller_if #(.ISSUE_WIDTH(IW), .AL_INDEX_WIDTH(AW)) dif ();

    div_unit_controller #(.ISSUE_WIDTH(IW), .AL_INDEX_WIDTH(AW), .DIV_LATENCY(LAT)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .div_if (dif)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input int n);
        repeat (n) tick();
    endtask

    task automatic clr();
        dif.stall           = 1'b0;
        dif.acquire         = '0;
        dif.acquire_ptr     = '0;
        dif.req             = '0;
        dif.divisor_is_zero = '0;
        dif.rel             = '0;
        dif.flush_valid     = 1'b0;
        dif.flush_all       = 1'b0;
        dif.flush_head_ptr  = '0;
        dif.flush_ptr       = '0;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        adv(2);
        #1;
        chk("rst_free",  dif.div_free,     2'b11);
        chk("rst_any",   2'(dif.any_free), 2'b01);
        chk("rst_res",   dif.div_reserved, 2'b00);
        chk("rst_busy",  dif.div_busy,     2'b00);
        chk("rst_fin",   dif.div_finished, 2'b00);
        chk("rst_start", dif.div_start,    2'b00);
        chk("rst_abort", dif.div_abort,    2'b00);
        rst = 1'b0;
        tick();

        // Basic lifecycle: acquire t0, req t0+1, busy t0+2..t0+32, finished t0+33
        dif.acquire = 2'b01; dif.acquire_ptr[0] = 6'd5;
        tick();                                   // t0+1
        dif.acquire = '0; dif.req = 2'b01; #1;
        chk("life_res",   dif.div_reserved, 2'b01);
        chk("life_start", dif.div_start,    2'b01);
        tick();                                   // t0+2
        dif.req = '0; #1;
        chk("life_busy_first", dif.div_busy,  2'b01);
        chk("life_start_once", dif.div_start, 2'b00);
        adv(30); #1;                              // t0+32
        chk("life_busy_last", dif.div_busy,     2'b01);
        chk("life_not_fin",   dif.div_finished, 2'b00);
        tick(); #1;                               // t0+33
        chk("life_fin",       dif.div_finished, 2'b01);
        chk("life_busy_done", dif.div_busy,     2'b00);
        tick();                                   // t0+34
        dif.rel = 2'b01; #1;
        chk("life_rel_noabort", dif.div_abort, 2'b00);
        tick();                                   // t0+35
        dif.rel = '0; #1;
        chk("life_free", dif.div_free, 2'b11);

        // Stalled req: only the unstalled cycle starts the divider
        dif.acquire = 2'b01; dif.acquire_ptr[0] = 6'd7;
        tick();
        dif.acquire = '0; dif.req = 2'b01; dif.stall = 1'b1; #1;
        chk("stall_start_a", dif.div_start, 2'b00);
        tick(); #1;
        chk("stall_start_b", dif.div_start, 2'b00);
        tick(); #1;
        chk("stall_start_c", dif.div_start, 2'b00);
        chk("stall_res",     dif.div_reserved, 2'b01);
        tick();                                   // s
        dif.stall = 1'b0; #1;
        chk("stall_go", dif.div_start, 2'b01);
        tick();                                   // s+1
        dif.req = '0; #1;
        chk("stall_busy", dif.div_busy, 2'b01);
        adv(30); #1;                              // s+31
        chk("stall_busy_last", dif.div_busy, 2'b01);
        tick(); #1;                               // s+32
        chk("stall_fin", dif.div_finished, 2'b01);

        // release + acquire on FINISHED: acquire dropped
        dif.rel = 2'b01; dif.acquire = 2'b01; dif.acquire_ptr[0] = 6'd9;
        tick();
        dif.rel = '0; dif.acquire = '0; #1;
        chk("relacq_free", dif.div_free,     2'b11);
        chk("relacq_res",  dif.div_reserved, 2'b00);

        // Flush during BUSY with wrap: head=60, owner=62
        dif.acquire = 2'b01; dif.acquire_ptr[0] = 6'd62;
        tick();
        dif.acquire = '0; dif.req = 2'b01;
        tick();
        dif.req = '0;
        dif.flush_valid = 1'b1; dif.flush_head_ptr = 6'd60; dif.flush_ptr = 6'd63; #1;
        chk("flush_older_abort", dif.div_abort, 2'b00);
        tick();
        dif.flush_valid = 1'b0; #1;
        chk("flush_older_busy", dif.div_busy, 2'b01);
        dif.flush_valid = 1'b1; dif.flush_ptr = 6'd61; #1;
        chk("flush_younger_abort", dif.div_abort, 2'b01);
        tick();
        clr(); #1;
        chk("flush_younger_free",  dif.div_free,  2'b11);
        chk("flush_younger_abort_done", dif.div_abort, 2'b00);

        // flush + release on FINISHED
        dif.acquire = 2'b01; dif.acquire_ptr[0] = 6'd10;
        tick();
        dif.acquire = '0; dif.req = 2'b01;
        tick();
        dif.req = '0;
        adv(30);
        tick(); #1;
        chk("flrel_fin", dif.div_finished, 2'b01);
        dif.flush_valid = 1'b1; dif.flush_all = 1'b1; dif.rel = 2'b01; #1;
        chk("flrel_abort", dif.div_abort, 2'b00);
        tick();
        clr(); #1;
        chk("flrel_free",  dif.div_free,  2'b11);
        chk("flrel_quiet", dif.div_abort, 2'b00);

        // divisor == 0
        dif.acquire = 2'b01; dif.acquire_ptr[0] = 6'd3;
        tick();
        dif.acquire = '0; dif.req = 2'b01; dif.divisor_is_zero = 2'b01; #1;
        chk("dz_start", dif.div_start, 2'b01);
        tick();
        dif.req = '0; dif.divisor_is_zero = '0; #1;
`ifdef RSD_DIV_EARLY_FINISH_EN
        chk("dz_fin", dif.div_finished, 2'b01);
        dif.rel = 2'b01; #1;
        chk("dz_rel_abort", dif.div_abort, 2'b00);
`else
        chk("dz_busy", dif.div_busy, 2'b01);
        dif.rel = 2'b01; #1;
        chk("dz_rel_abort", dif.div_abort, 2'b01);
`endif
        tick();
        dif.rel = '0; #1;
        chk("dz_free", dif.div_free, 2'b11);

        // Two lanes and async reset
        dif.acquire = 2'b01; dif.acquire_ptr[0] = 6'd1;
        tick();
        dif.acquire = '0; dif.req = 2'b01;
        tick();
        dif.req = '0; #1;
        chk("two_busy0", dif.div_busy,       2'b01);
        chk("two_any1",  2'(dif.any_free),   2'b01);
        dif.acquire = 2'b10; dif.acquire_ptr[1] = 6'd2;
        tick();
        dif.acquire = '0; #1;
        chk("two_any0", 2'(dif.any_free), 2'b00);
        chk("two_res1", dif.div_reserved, 2'b10);
        rst = 1'b1; #1;
        chk("arst_free",  dif.div_free,     2'b11);
        chk("arst_any",   2'(dif.any_free), 2'b01);
        chk("arst_busy",  dif.div_busy,     2'b00);
        chk("arst_abort", dif.div_abort,    2'b00);
        rst = 1'b0;
        tick(); #1;
        chk("arst_hold", dif.div_free, 2'b11);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
